// File: rtl/controller_pkg.sv
// Shared definitions for the NES-style gamepad poller.
// - state_t and its localparam encodings: poller FSM states
// - NUM_BUTTONS: bits per pad
// - BTN_*: bit positions in the active-high button bytes (first bit shifted in lands in bit 7)
package controller_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle  = 3'd0;
  localparam state_t StLatch = 3'd1;
  localparam state_t StLow   = 3'd2;
  localparam state_t StHigh  = 3'd3;
  localparam state_t StDone  = 3'd4;

  localparam int unsigned NUM_BUTTONS = 8;

  localparam int unsigned BTN_A      = 7;
  localparam int unsigned BTN_B      = 6;
  localparam int unsigned BTN_SELECT = 5;
  localparam int unsigned BTN_START  = 4;
  localparam int unsigned BTN_UP     = 3;
  localparam int unsigned BTN_DOWN   = 2;
  localparam int unsigned BTN_LEFT   = 1;
  localparam int unsigned BTN_RIGHT  = 0;

endpackage

// File: rtl/controller_shifter.sv
// Per-pad data path: 2-flop synchronizer, shadow shift register, published button register.
// Ports:
//   clk_12_5875  system clock
//   rst_B        async active-low reset
//   data_in_B    pad serial data, active low, asynchronous
//   sample_i     shift one synchronized bit into the shadow register
//   publish_i    with sample_i: this is the final bit, update the output register too
//   buttons_o    active-high button byte, changes only on publish
module controller_shifter
  import controller_pkg::*;
#(
  parameter int unsigned NUM_BITS = NUM_BUTTONS
) (
  input  logic                clk_12_5875,
  input  logic                rst_B,
  input  logic                data_in_B,
  input  logic                sample_i,
  input  logic                publish_i,
  output logic [NUM_BITS-1:0] buttons_o
);

  logic [1:0]          sync_q;
  logic [NUM_BITS-1:0] shadow_q;
  logic [NUM_BITS-1:0] buttons_q;
  logic [NUM_BITS-1:0] shifted;

  // Invert on entry so the shadow register is already active-high.
  assign shifted = {shadow_q[NUM_BITS-2:0], ~sync_q[1]};

  always_ff @(posedge clk_12_5875 or negedge rst_B) begin
    if (!rst_B) begin
      sync_q    <= 2'b11;
      shadow_q  <= '0;
      buttons_q <= '0;
    end else begin
      sync_q <= {sync_q[0], data_in_B};
      if (sample_i) begin
        shadow_q <= shifted;
        // Load the completed byte directly so it appears together with valid.
        if (publish_i) begin
          buttons_q <= shifted;
        end
      end
    end
  end

  assign buttons_o = buttons_q;

endmodule

// File: rtl/controller_poller.sv
// Sequencer for two NES-style serial gamepads sharing latch/clock pins.
// Ports:
//   clk_12_5875, rst_B          system clock, async active-low reset
//   start                       poll request (pulse or level)
//   controller_clk/_latch       shared pad shift clock and parallel-load strobe
//   controller_N_data_in_B      pad serial data, active low
//   controller_N_buttons        active-high button bytes, updated atomically
//   busy                        poll in progress (LATCH..DONE)
//   valid                       one-cycle pulse when the button bytes update
module controller_poller
  import controller_pkg::*;
#(
  parameter int unsigned PHASE    = 64,
  parameter int unsigned NUM_BITS = NUM_BUTTONS
) (
  input  logic                clk_12_5875,
  input  logic                rst_B,
  input  logic                start,
  output logic                controller_clk,
  output logic                controller_latch,
  input  logic                controller_1_data_in_B,
  input  logic                controller_2_data_in_B,
  output logic [NUM_BITS-1:0] controller_1_buttons,
  output logic [NUM_BITS-1:0] controller_2_buttons,
  output logic                busy,
  output logic                valid
);

  localparam int unsigned PhaseW = $clog2(PHASE);
  localparam int unsigned BitW   = $clog2(NUM_BITS + 1);
  localparam logic [PhaseW-1:0] PhaseLast = PhaseW'(PHASE - 1);
  localparam logic [BitW-1:0]   BitLast   = BitW'(NUM_BITS - 1);

  state_t            state_q, state_d;
  logic [PhaseW-1:0] phase_q, phase_d;
  logic [BitW-1:0]   bit_q, bit_d;
  logic              clk_q, latch_q, busy_q, valid_q;
  logic              phase_last;
  logic              sample;
  logic              publish;

  assign phase_last = (phase_q == PhaseLast);
  assign publish    = (bit_q == BitLast);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q + PhaseW'(1);
    bit_d   = bit_q;
    sample  = 1'b0;
    case (state_q)
      StIdle: begin
        phase_d = '0;
        if (start) begin
          state_d = StLatch;
          bit_d   = '0;
        end
      end
      StLatch: begin
        if (phase_last) begin
          state_d = StLow;
          phase_d = '0;
        end
      end
      StLow: begin
        if (phase_last) begin
          sample  = 1'b1;
          bit_d   = bit_q + BitW'(1);
          phase_d = '0;
          state_d = publish ? StDone : StHigh;
        end
      end
      StHigh: begin
        if (phase_last) begin
          state_d = StLow;
          phase_d = '0;
        end
      end
      StDone: begin
        state_d = StIdle;
        phase_d = '0;
      end
      default: begin
        state_d = StIdle;
        phase_d = '0;
      end
    endcase
  end

  // Pin and status outputs are registered from the next state so they are glitch-free
  // and always agree with state_q.
  always_ff @(posedge clk_12_5875 or negedge rst_B) begin
    if (!rst_B) begin
      state_q <= StIdle;
      phase_q <= '0;
      bit_q   <= '0;
      clk_q   <= 1'b0;
      latch_q <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      clk_q   <= (state_d == StHigh);
      latch_q <= (state_d == StLatch);
      busy_q  <= (state_d != StIdle);
      valid_q <= (state_d == StDone);
    end
  end

  assign controller_clk   = clk_q;
  assign controller_latch = latch_q;
  assign busy             = busy_q;
  assign valid            = valid_q;

  controller_shifter #(
    .NUM_BITS (NUM_BITS)
  ) u_pad1 (
    .clk_12_5875 (clk_12_5875),
    .rst_B       (rst_B),
    .data_in_B   (controller_1_data_in_B),
    .sample_i    (sample),
    .publish_i   (publish),
    .buttons_o   (controller_1_buttons)
  );

  controller_shifter #(
    .NUM_BITS (NUM_BITS)
  ) u_pad2 (
    .clk_12_5875 (clk_12_5875),
    .rst_B       (rst_B),
    .data_in_B   (controller_2_data_in_B),
    .sample_i    (sample),
    .publish_i   (publish),
    .buttons_o   (controller_2_buttons)
  );

endmodule

// File: tb/tb_controller_poller.sv
// Bench for controller_poller with PHASE=4: two MSB-first pad models, a start-acceptance
// reference model feeding a scoreboard queue, and a monitor that checks every cycle.
module tb_controller_poller;

  localparam int unsigned PHASE = 4;
  // Cycles from the accepting edge to the edge that enters DONE: 2*NUM_BITS*PHASE.
  localparam int POLL_LEN = 64;

  logic       clk = 1'b0;
  logic       rst_B;
  logic       start;
  logic       controller_clk;
  logic       controller_latch;
  logic       data1_B, data2_B;
  logic [7:0] buttons1, buttons2;
  logic       busy, valid;

  controller_poller #(
    .PHASE    (PHASE),
    .NUM_BITS (8)
  ) dut (
    .clk_12_5875            (clk),
    .rst_B                  (rst_B),
    .start                  (start),
    .controller_clk         (controller_clk),
    .controller_latch       (controller_latch),
    .controller_1_data_in_B (data1_B),
    .controller_2_data_in_B (data2_B),
    .controller_1_buttons   (buttons1),
    .controller_2_buttons   (buttons2),
    .busy                   (busy),
    .valid                  (valid)
  );

  always #5 clk = ~clk;

  // ---------------- pad models ----------------
  logic [7:0] pad1 = 8'h00, pad2 = 8'h00;
  logic [7:0] snap1 = 8'h00, snap2 = 8'h00;
  int         idx = 8;
  logic       stuck_en = 1'b0, stuck_val = 1'b1;

  always @(posedge controller_latch or posedge controller_clk) begin
    if (controller_latch) begin
      snap1 = pad1;
      snap2 = pad2;
      idx   = 0;
    end else begin
      idx = idx + 1;
    end
  end

  assign data1_B = stuck_en ? stuck_val : ((idx < 8) ? ~snap1[7-idx] : 1'b1);
  assign data2_B = stuck_en ? stuck_val : ((idx < 8) ? ~snap2[7-idx] : 1'b1);

  function automatic logic [7:0] pad_exp(input logic [7:0] p);
    if (stuck_en) return stuck_val ? 8'h00 : 8'hFF;
    return p;
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    int         cyc;
    logic [7:0] b1;
    logic [7:0] b2;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   free_edge = 0;
  int   act_k = -1000;

  // A poll occupies POLL_LEN+1 cycles after the accepting edge, then one IDLE cycle.
  always @(posedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    if (!rst_B) begin
      free_edge = 0;
      act_k     = -1000;
    end else if (start && cyc >= free_edge) begin
      e.cyc = cyc + POLL_LEN;
      e.b1  = pad_exp(pad1);
      e.b2  = pad_exp(pad2);
      q.push_back(e);
      act_k     = cyc;
      free_edge = cyc + POLL_LEN + 2;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] hold1 = 8'h00, hold2 = 8'h00;
  int         latch_cnt = 0, clk_rises = 0;
  logic       prev_clk = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  always @(negedge clk or negedge rst_B) begin
    exp_t e;
    if (!rst_B) begin
      #1;
      chk("rst_clk",   {31'd0, controller_clk},   32'd0);
      chk("rst_latch", {31'd0, controller_latch}, 32'd0);
      chk("rst_busy",  {31'd0, busy},             32'd0);
      chk("rst_valid", {31'd0, valid},            32'd0);
      chk("rst_btn1",  {24'd0, buttons1},         32'd0);
      chk("rst_btn2",  {24'd0, buttons2},         32'd0);
      q.delete();
      hold1 = 8'h00;
      hold2 = 8'h00;
      latch_cnt = 0;
      clk_rises = 0;
      prev_clk  = 1'b0;
    end else begin
      chk("busy", {31'd0, busy}, {31'd0, (cyc >= act_k && cyc <= act_k + POLL_LEN)});
      if (controller_latch) latch_cnt++;
      if (controller_clk && !prev_clk) clk_rises++;
      prev_clk = controller_clk;
      if (valid) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          chk("valid_cycle", cyc,                e.cyc);
          chk("btn1",        {24'd0, buttons1},  {24'd0, e.b1});
          chk("btn2",        {24'd0, buttons2},  {24'd0, e.b2});
          chk("latch_len",   latch_cnt,          PHASE);
          chk("clk_rises",   clk_rises,          7);
          hold1 = e.b1;
          hold2 = e.b2;
        end
        latch_cnt = 0;
        clk_rises = 0;
      end else begin
        chk("hold1", {24'd0, buttons1}, {24'd0, hold1});
        chk("hold2", {24'd0, buttons2}, {24'd0, hold2});
        if (q.size() != 0 && cyc > q[0].cyc) begin
          chk("missing_valid", 32'd0, 32'd1);
          void'(q.pop_front());
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  // Drive start so that it is sampled at edge e.
  task automatic pulse_at(input int e);
    while (cyc + 1 < e) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int k;

  initial begin
    rst_B = 1'b0;
    start = 1'b0;
    idle(3);
    rst_B = 1'b1;
    idle(2);

    // Basic poll, busy rejection, hold behaviour, then an accepted follow-up poll.
    pad1 = 8'b1000_1000;
    pad2 = 8'b0010_0110;
    k = cyc + 1;
    pulse_at(k);
    pulse_at(k + 10);
    while (cyc + 1 < k + 20) @(negedge clk);
    pad1 = 8'hFF;
    pulse_at(k + 65);
    pulse_at(k + 67);
    idle(80);

    // Mid-poll asynchronous reset, then a fresh poll.
    pad1 = 8'h5A;
    pad2 = 8'hC3;
    k = cyc + 1;
    pulse_at(k);
    while (cyc < k + 30) @(negedge clk);
    @(posedge clk);
    #2 rst_B = 1'b0;
    idle(2);
    rst_B = 1'b1;
    pad1 = 8'h3C;
    pad2 = 8'h81;
    pulse_at(cyc + 2);
    idle(75);

    // Disconnected pad (data high) and stuck-low pad.
    stuck_en  = 1'b1;
    stuck_val = 1'b1;
    pulse_at(cyc + 1);
    idle(70);
    stuck_val = 1'b0;
    pulse_at(cyc + 1);
    idle(70);
    stuck_en = 1'b0;

    // start held high: back-to-back polls with one IDLE cycle between.
    pad1  = 8'hA5;
    pad2  = 8'h0F;
    start = 1'b1;
    idle(3 * (POLL_LEN + 2));
    start = 1'b0;
    idle(80);

    // Random start pulses and pad contents.
    for (int i = 0; i < 600; i++) begin
      if (i % 8 == 0) begin
        pad1 = 8'($urandom);
        pad2 = 8'($urandom);
      end
      start = ($urandom_range(0, 9) == 0);
      @(negedge clk);
    end
    start = 1'b0;
    idle(80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
